memory_arbiter: RTL and testbench



---
 rtl/memory_arbiter_pkg.sv | 25 ++
 rtl/rr_arbiter_2.sv | 29 ++
 rtl/memory_arbiter.sv | 147 ++++++++++++++
 tb/tb_memory_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// ============================================================================
// mem_arb_pkg : shared types and constants for the two-port memory arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_DATA   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_2.sv
// ============================================================================
// rr_arbiter_2 : combinational two-way round-robin picker
// Revision     : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter_2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = PORT_IFETCH;
    if (&req) begin
      // On a tie the port that did not win last time goes next.
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = PORT_DATA;
    end
  end

endmodule

`default_nettype wire

// File: rtl/memory_arbiter.sv
// ============================================================================
// memory_arbiter : round-robin sharing of one controller port between the
//                  instruction-fetch and data requesters, with abort timeout
// Revision       : 1.0
// ============================================================================
`default_nettype none

module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic                  p0_read_en,
  input  logic                  p0_write_en,
  input  logic [DATA_WIDTH-1:0] p0_write_val,
  output logic [DATA_WIDTH-1:0] p0_read_val,
  output logic                  p0_response,
  output logic                  p0_error,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic                  p1_read_en,
  input  logic                  p1_write_en,
  input  logic [DATA_WIDTH-1:0] p1_write_val,
  output logic [DATA_WIDTH-1:0] p1_read_val,
  output logic                  p1_response,
  output logic                  p1_error,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [DATA_WIDTH-1:0] mem_write_val,
  input  logic [DATA_WIDTH-1:0] mem_read_val,
  input  logic                  mem_response
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_t           state, state_nx;
  op_t              op;
  logic             gnt;
  logic             last_grant;
  logic             err_flag;
  logic [CNT_W-1:0] tcnt;
  logic [CNT_W-1:0] tcnt_inc;
  logic             timeout_hit;
  logic [1:0]       req;
  logic             pick;
  logic             pick_valid;

  assign req = {p1_read_en | p1_write_en, p0_read_en | p0_write_en};

  rr_arbiter_2 u_rr (
    .req        (req),
    .last_grant (last_grant),
    .grant      (pick),
    .valid      (pick_valid)
  );

  assign tcnt_inc    = tcnt + CNT_W'(1);
  // Abort once the count after this ISSUE cycle would reach the limit.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    p0_response  = 1'b0;
    p1_response  = 1'b0;
    p0_error     = 1'b0;
    p1_error     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) state_nx = ISSUE;
      end
      ISSUE: begin
        mem_read_en  = (op == OP_READ);
        mem_write_en = (op == OP_WRITE);
        if (mem_response || timeout_hit) state_nx = RESP;
      end
      RESP: begin
        p0_response = (gnt == PORT_IFETCH);
        p1_response = (gnt == PORT_DATA);
        p0_error    = (gnt == PORT_IFETCH) && err_flag;
        p1_error    = (gnt == PORT_DATA) && err_flag;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt           <= PORT_IFETCH;
      last_grant    <= PORT_DATA;
      op            <= OP_READ;
      err_flag      <= 1'b0;
      tcnt          <= '0;
      mem_addr      <= '0;
      mem_write_val <= '0;
      p0_read_val   <= '0;
      p1_read_val   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt        <= pick;
            last_grant <= pick;
            err_flag   <= 1'b0;
            tcnt       <= '0;
            if (pick == PORT_DATA) begin
              mem_addr      <= p1_addr;
              mem_write_val <= p1_write_val;
              op            <= p1_write_en ? OP_WRITE : OP_READ;
            end else begin
              mem_addr      <= p0_addr;
              mem_write_val <= p0_write_val;
              op            <= p0_write_en ? OP_WRITE : OP_READ;
            end
          end
        end
        ISSUE: begin
          tcnt <= tcnt_inc;
          if (mem_response) begin
            if (op == OP_READ) begin
              if (gnt == PORT_DATA) p1_read_val <= mem_read_val;
              else                  p0_read_val <= mem_read_val;
            end
          end else if (timeout_hit) begin
            err_flag <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
// ============================================================================
// tb_memory_arbiter : directed self-checking bench for memory_arbiter
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_memory_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  // Instance A: default timeout (effectively none for these tests)
  logic [31:0] a_p0_addr = '0, a_p0_write_val = '0, a_p1_addr = '0, a_p1_write_val = '0;
  logic        a_p0_read_en = 0, a_p0_write_en = 0, a_p1_read_en = 0, a_p1_write_en = 0;
  logic [31:0] a_p0_read_val, a_p1_read_val, a_mem_addr, a_mem_write_val;
  logic        a_p0_response, a_p0_error, a_p1_response, a_p1_error;
  logic        a_mem_read_en, a_mem_write_en;
  logic [31:0] a_mem_read_val = '0;
  logic        a_mem_response = 1'b0;

  // Instance B: TIMEOUT_CYCLES = 4
  logic [31:0] b_p0_addr = '0, b_zero = '0;
  logic        b_p0_read_en = 0, b_low = 0;
  logic [31:0] b_p0_read_val, b_p1_read_val, b_mem_addr, b_mem_write_val;
  logic        b_p0_response, b_p0_error, b_p1_response, b_p1_error;
  logic        b_mem_read_en, b_mem_write_en;
  logic [31:0] b_mem_read_val = '0;
  logic        b_mem_response = 1'b0;

  always #5 clk = ~clk;

  memory_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_addr(a_p0_addr), .p0_read_en(a_p0_read_en), .p0_write_en(a_p0_write_en),
    .p0_write_val(a_p0_write_val), .p0_read_val(a_p0_read_val),
    .p0_response(a_p0_response), .p0_error(a_p0_error),
    .p1_addr(a_p1_addr), .p1_read_en(a_p1_read_en), .p1_write_en(a_p1_write_en),
    .p1_write_val(a_p1_write_val), .p1_read_val(a_p1_read_val),
    .p1_response(a_p1_response), .p1_error(a_p1_error),
    .mem_addr(a_mem_addr), .mem_read_en(a_mem_read_en), .mem_write_en(a_mem_write_en),
    .mem_write_val(a_mem_write_val), .mem_read_val(a_mem_read_val),
    .mem_response(a_mem_response)
  );

  memory_arbiter #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .reset(reset),
    .p0_addr(b_p0_addr), .p0_read_en(b_p0_read_en), .p0_write_en(b_low),
    .p0_write_val(b_zero), .p0_read_val(b_p0_read_val),
    .p0_response(b_p0_response), .p0_error(b_p0_error),
    .p1_addr(b_zero), .p1_read_en(b_low), .p1_write_en(b_low),
    .p1_write_val(b_zero), .p1_read_val(b_p1_read_val),
    .p1_response(b_p1_response), .p1_error(b_p1_error),
    .mem_addr(b_mem_addr), .mem_read_en(b_mem_read_en), .mem_write_en(b_mem_write_en),
    .mem_write_val(b_mem_write_val), .mem_read_val(b_mem_read_val),
    .mem_response(b_mem_response)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for instance A to issue, hold off `delay` cycles, then ack.
  // Returns in the RESP cycle.
  task automatic serve(input int delay, input logic [31:0] rdata);
    int n;
    n = 0;
    while (!(a_mem_read_en || a_mem_write_en) && n < 20) begin
      tick();
      n++;
    end
    chk("issue_seen", {31'b0, a_mem_read_en | a_mem_write_en}, 32'd1);
    repeat (delay) tick();
    a_mem_response = 1'b1;
    a_mem_read_val = rdata;
    tick();
    a_mem_response = 1'b0;
    a_mem_read_val = '0;
  endtask

  initial begin
    int n;
    // ---- reset state
    tick();
    tick();
    chk("rst_mem_read_en", {31'b0, a_mem_read_en}, 32'd0);
    chk("rst_mem_write_en", {31'b0, a_mem_write_en}, 32'd0);
    chk("rst_mem_addr", a_mem_addr, 32'd0);
    chk("rst_p0_response", {31'b0, a_p0_response}, 32'd0);
    chk("rst_p1_read_val", a_p1_read_val, 32'd0);
    reset = 1'b0;
    tick();

    // ---- single write on p1
    a_p1_write_en = 1; a_p1_addr = 32'h04; a_p1_write_val = 32'h5;
    tick();
    chk("w1_write_en", {31'b0, a_mem_write_en}, 32'd1);
    chk("w1_read_en", {31'b0, a_mem_read_en}, 32'd0);
    chk("w1_addr", a_mem_addr, 32'h04);
    chk("w1_val", a_mem_write_val, 32'h5);
    serve(0, 32'h0);
    chk("w1_p1_resp", {31'b0, a_p1_response}, 32'd1);
    chk("w1_p0_resp", {31'b0, a_p0_response}, 32'd0);
    chk("w1_p1_err", {31'b0, a_p1_error}, 32'd0);
    chk("w1_en_low", {31'b0, a_mem_write_en}, 32'd0);
    a_p1_write_en = 0;
    tick();
    chk("w1_resp_one_cycle", {31'b0, a_p1_response}, 32'd0);
    chk("w1_addr_hold", a_mem_addr, 32'h04);

    // ---- p0 writes 0x3 to addr 2, p1 reads it back
    a_p0_write_en = 1; a_p0_addr = 32'h2; a_p0_write_val = 32'h3;
    tick();
    serve(0, 32'h0);
    chk("w2_p0_resp", {31'b0, a_p0_response}, 32'd1);
    a_p0_write_en = 0;
    tick();
    a_p1_read_en = 1; a_p1_addr = 32'h2;
    tick();
    chk("r2_read_en", {31'b0, a_mem_read_en}, 32'd1);
    chk("r2_addr", a_mem_addr, 32'h2);
    serve(0, 32'h3);
    chk("r2_p1_resp", {31'b0, a_p1_response}, 32'd1);
    chk("r2_p1_val", a_p1_read_val, 32'h3);
    a_p1_read_en = 0;
    tick();

    // ---- continuous contention from reset: grants 0,1,0,1,...
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_p0_read_en = 1; a_p0_addr = 32'h10;
    a_p1_read_en = 1; a_p1_addr = 32'h20;
    for (int i = 0; i < 8; i++) begin
      serve(0, 32'h100 + 32'(i));
      chk($sformatf("rr%0d_addr", i), a_mem_addr, (i % 2 == 0) ? 32'h10 : 32'h20);
      chk($sformatf("rr%0d_p0_resp", i), {31'b0, a_p0_response}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_p1_resp", i), {31'b0, a_p1_response}, (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i % 2 == 0) chk($sformatf("rr%0d_val", i), a_p0_read_val, 32'h100 + 32'(i));
      else            chk($sformatf("rr%0d_val", i), a_p1_read_val, 32'h100 + 32'(i));
      tick();
    end
    a_p0_read_en = 0; a_p1_read_en = 0;
    tick();
    chk("rr_p0_final", a_p0_read_val, 32'h106);
    chk("rr_p1_final", a_p1_read_val, 32'h107);

    // ---- reset in the middle of ISSUE
    a_p1_write_en = 1; a_p1_addr = 32'h60; a_p1_write_val = 32'h9;
    tick();
    chk("mr_issuing", {31'b0, a_mem_write_en}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mr_write_en", {31'b0, a_mem_write_en}, 32'd0);
    chk("mr_addr", a_mem_addr, 32'd0);
    chk("mr_p0_val", a_p0_read_val, 32'd0);
    tick();
    chk("mr_no_resp", {31'b0, a_p1_response}, 32'd0);
    reset = 1'b0;
    a_p0_read_en = 1; a_p0_addr = 32'h70;
    tick();
    chk("mr_tie_port0", a_mem_addr, 32'h70);
    serve(0, 32'h0);
    chk("mr_p0_resp", {31'b0, a_p0_response}, 32'd1);
    a_p0_read_en = 0; a_p1_write_en = 0;
    tick();
    tick();

    // ---- delayed controller response (7 cycles)
    a_p0_read_en = 1; a_p0_addr = 32'h30;
    tick();
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("dl%0d_hold", i), {a_mem_addr[29:0], a_mem_read_en, a_p0_response},
          {30'h30, 1'b1, 1'b0});
      tick();
    end
    a_mem_response = 1'b1; a_mem_read_val = 32'hAB;
    tick();
    a_mem_response = 1'b0; a_mem_read_val = '0;
    chk("dl_resp", {31'b0, a_p0_response}, 32'd1);
    chk("dl_err", {31'b0, a_p0_error}, 32'd0);
    chk("dl_val", a_p0_read_val, 32'hAB);
    a_p0_read_en = 0;
    tick();

    // ---- read and write together: write wins
    a_p0_read_en = 1; a_p0_write_en = 1; a_p0_addr = 32'h50; a_p0_write_val = 32'h77;
    tick();
    chk("rw_write_en", {31'b0, a_mem_write_en}, 32'd1);
    chk("rw_read_en", {31'b0, a_mem_read_en}, 32'd0);
    chk("rw_val", a_mem_write_val, 32'h77);
    serve(0, 32'hDEAD);
    chk("rw_resp", {31'b0, a_p0_response}, 32'd1);
    chk("rw_read_val_kept", a_p0_read_val, 32'hAB);
    a_p0_read_en = 0; a_p0_write_en = 0;
    tick();

    // ---- timeout on instance B (limit 4)
    b_p0_read_en = 1; b_p0_addr = 32'h40;
    tick();
    n = 0;
    while (b_mem_read_en && n < 10) begin
      n++;
      chk($sformatf("to%0d_no_resp", n), {31'b0, b_p0_response}, 32'd0);
      tick();
    end
    chk("to_cycles", 32'(n), 32'd4);
    chk("to_resp", {31'b0, b_p0_response}, 32'd1);
    chk("to_err", {31'b0, b_p0_error}, 32'd1);
    chk("to_read_en", {31'b0, b_mem_read_en}, 32'd0);
    chk("to_val", b_p0_read_val, 32'd0);
    b_p0_read_en = 0;
    b_mem_response = 1'b1; b_mem_read_val = 32'hFF;
    tick();
    tick();
    b_mem_response = 1'b0; b_mem_read_val = '0;
    chk("to_late_resp", {31'b0, b_p0_response}, 32'd0);
    chk("to_late_val", b_p0_read_val, 32'd0);
    chk("to_late_idle", {31'b0, b_mem_read_en}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
